// File: rtl/simif_master.sv
// simif_master: byte-stream initiator for the simulator interface slave.
// Probes the slave with DETECT, then forwards bytes as PRINT/char pairs.
module simif_master #(
   parameter int WIDTH   = 32,
   parameter int FIFO_AW = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [7:0]       in_data,
   output logic             in_ready,
   input  logic             redetect,
   output logic             m_cs,
   output logic             m_wen,
   output logic             m_addr,
   output logic [WIDTH-1:0] m_dout,
   input  logic [WIDTH-1:0] m_din,
   output logic             present,
   output logic             detect_done,
   output logic             busy,
   output logic [15:0]      drop_cnt
);

   localparam int DEPTH = 1 << FIFO_AW;
   localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW+1)'(DEPTH);

   localparam logic [7:0] CMD_PRINT  = 8'h70;
   localparam logic [7:0] CMD_DETECT = 8'h5f;
   localparam logic [7:0] DET_ANSWER = 8'h21;

   typedef enum logic [2:0] {
      S_SYNC,
      S_DET_W,
      S_DET_R,
      S_IDLE,
      S_P_CMD,
      S_P_PAR
   } state_t;

   state_t state;

   logic [7:0]         mem [DEPTH];
   logic [FIFO_AW-1:0] wptr;
   logic [FIFO_AW-1:0] rptr;
   logic [FIFO_AW:0]   count;
   logic               pend;

   logic       empty;
   logic       full;
   logic       push;
   logic       pop;
   logic       drop;
   logic       go_det;
   logic [7:0] head;

   logic       bus_cs;
   logic       bus_wen;
   logic [7:0] bus_data;

   // only the low byte of the slave read data carries the DETECT answer
   logic unused_din;
   assign unused_din = ^m_din[WIDTH-1:8];

   assign empty    = (count == '0);
   assign full     = (count == FULL_CNT);
   assign in_ready = ~full;
   assign push     = in_valid & ~full;
   assign head     = mem[rptr];

   // without a simulator attached, bytes are discarded one per idle cycle
   assign drop = (state == S_IDLE) & ~pend & ~empty & ~present;
   assign pop  = ~empty & ((state == S_P_PAR) | drop);

   // any transition that lands in DET_W consumes the pending request
   assign go_det = (state == S_SYNC) |
                   ((state == S_IDLE)  & pend) |
                   ((state == S_P_PAR) & pend);

   assign busy = (state != S_IDLE) | ~empty;

   // FIFO storage; contents need no reset, occupancy is tracked by count
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wptr] <= in_data;
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk) begin
      if (!reset) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) begin
            wptr <= wptr + 1'b1;
         end
         if (pop) begin
            rptr <= rptr + 1'b1;
         end
         unique case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // redetect request latch; a new request beats the clear on DET_W entry
   always_ff @(posedge clk) begin
      if (!reset) begin
         pend <= 1'b0;
      end else if (redetect) begin
         pend <= 1'b1;
      end else if (go_det) begin
         pend <= 1'b0;
      end
   end

   // main sequencer plus detect status and drop counter
   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= S_SYNC;
         present     <= 1'b0;
         detect_done <= 1'b0;
         drop_cnt    <= '0;
      end else begin
         unique case (state)
            S_SYNC: begin
               state <= S_DET_W;
            end
            S_DET_W: begin
               state <= S_DET_R;
            end
            S_DET_R: begin
               present     <= (m_din[7:0] == DET_ANSWER);
               detect_done <= 1'b1;
               state       <= S_IDLE;
            end
            S_IDLE: begin
               if (pend) begin
                  state <= S_DET_W;
               end else if (!empty && present) begin
                  state <= S_P_CMD;
               end else if (drop) begin
                  if (drop_cnt != 16'hffff) begin
                     drop_cnt <= drop_cnt + 16'd1;
                  end
               end
            end
            S_P_CMD: begin
               state <= S_P_PAR;
            end
            S_P_PAR: begin
               if (pend) begin
                  state <= S_DET_W;
               end else if ((count > 1) && present) begin
                  state <= S_P_CMD;
               end else begin
                  state <= S_IDLE;
               end
            end
            default: begin
               state <= S_SYNC;
            end
         endcase
      end
   end

   // Moore decode of the bus, forced quiet while reset is held low
   always_comb begin
      bus_cs   = 1'b0;
      bus_wen  = 1'b0;
      bus_data = 8'h00;
      unique case (state)
         S_SYNC: begin
            bus_cs  = 1'b1;
            bus_wen = 1'b1;
         end
         S_DET_W: begin
            bus_cs   = 1'b1;
            bus_wen  = 1'b1;
            bus_data = CMD_DETECT;
         end
         S_DET_R: begin
            bus_cs = 1'b1;
         end
         S_P_CMD: begin
            bus_cs   = 1'b1;
            bus_wen  = 1'b1;
            bus_data = CMD_PRINT;
         end
         S_P_PAR: begin
            bus_cs   = 1'b1;
            bus_wen  = 1'b1;
            bus_data = head;
         end
         default: begin
            bus_cs = 1'b0;
         end
      endcase
      if (!reset) begin
         bus_cs   = 1'b0;
         bus_wen  = 1'b0;
         bus_data = 8'h00;
      end
   end

   assign m_cs   = bus_cs;
   assign m_wen  = bus_wen;
   assign m_addr = 1'b0;
   assign m_dout = {{(WIDTH-8){1'b0}}, bus_data};

endmodule

// File: tb/tb_simif_master.sv
// tb_simif_master: scoreboard bench for simif_master.
// Expected bus cycles are queued by stimulus and consumed by a monitor.
module tb_simif_master;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        in_ready;
   logic        redetect = 1'b0;
   logic        m_cs;
   logic        m_wen;
   logic        m_addr;
   logic [31:0] m_dout;
   logic [31:0] m_din = 32'h21;
   logic        present;
   logic        detect_done;
   logic        busy;
   logic [15:0] drop_cnt;

   int total = 0;
   int bad = 0;

   // bit 32 set = read cycle, else write with data in [31:0]
   logic [32:0] exp_q[$];
   logic [32:0] mon_e;
   logic [32:0] mon_a;

   simif_master #(.WIDTH(32), .FIFO_AW(2)) dut (
      .clk(clk),
      .reset(reset),
      .in_valid(in_valid),
      .in_data(in_data),
      .in_ready(in_ready),
      .redetect(redetect),
      .m_cs(m_cs),
      .m_wen(m_wen),
      .m_addr(m_addr),
      .m_dout(m_dout),
      .m_din(m_din),
      .present(present),
      .detect_done(detect_done),
      .busy(busy),
      .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%h exp=%h", nm, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic exp_w(logic [7:0] d);
      exp_q.push_back({1'b0, 24'h0, d});
   endtask

   task automatic exp_r;
      exp_q.push_back({1'b1, 32'h0});
   endtask

   task automatic pulse_redetect;
      redetect = 1'b1;
      tick;
      redetect = 1'b0;
      tick;
   endtask

   task automatic wait_idle(string nm);
      int n;
      n = 0;
      @(negedge clk);
      while (busy && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk(nm, 32'(busy), 32'd0);
      @(posedge clk);
      #1;
   endtask

   // bus monitor: every selected cycle must match the queue head
   always @(negedge clk) begin
      if (m_cs) begin
         mon_a = {~m_wen, (m_wen ? m_dout : 32'h0)};
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL bus_extra act=%h exp=none", mon_a);
         end else begin
            mon_e = exp_q.pop_front();
            if (mon_a !== mon_e || m_addr !== 1'b0) begin
               bad++;
               $display("FAIL bus_seq act=%h addr=%b exp=%h",
                        mon_a, m_addr, mon_e);
            end
         end
      end
   end

   initial begin
      int sent;
      int n;
      logic saw_block;
      logic xfer;

      // reset state
      repeat (3) tick;
      @(negedge clk);
      chk("rst_cs", 32'(m_cs), 32'd0);
      chk("rst_dout", m_dout, 32'd0);
      chk("rst_present", 32'(present), 32'd0);
      chk("rst_detdone", 32'(detect_done), 32'd0);
      chk("rst_drop", 32'(drop_cnt), 32'd0);
      chk("rst_ready", 32'(in_ready), 32'd1);

      // test 1: SYNC, DETECT write, read answered 0x21
      exp_w(8'h00);
      exp_w(8'h5f);
      exp_r;
      tick;
      reset = 1'b1;
      repeat (3) tick;
      chk("t1_present", 32'(present), 32'd1);
      chk("t1_detdone", 32'(detect_done), 32'd1);
      chk("t1_busy", 32'(busy), 32'd0);

      // test 2: two bytes, four back-to-back writes
      exp_w(8'h70);
      exp_w(8'h48);
      exp_w(8'h70);
      exp_w(8'h69);
      in_valid = 1'b1;
      in_data = 8'h48;
      tick;
      in_data = 8'h69;
      tick;
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("t2_b2b", 32'({m_cs, m_wen}), 32'd3);
         tick;
      end
      @(negedge clk);
      chk("t2_busy_fall", 32'(busy), 32'd0);
      tick;

      // test 3: six bytes through a four-deep FIFO
      for (int i = 0; i < 6; i++) begin
         exp_w(8'h70);
         exp_w(8'(8'h41 + i));
      end
      sent = 0;
      n = 0;
      saw_block = 1'b0;
      in_valid = 1'b1;
      while (sent < 6 && n < 100) begin
         in_data = 8'(8'h41 + sent);
         @(negedge clk);
         xfer = in_ready;
         if (!in_ready) saw_block = 1'b1;
         tick;
         if (xfer) sent++;
         n++;
      end
      in_valid = 1'b0;
      chk("t3_sent", 32'(sent), 32'd6);
      chk("t3_backpressure", 32'(saw_block), 32'd1);
      wait_idle("t3_idle");
      chk("t3_q_empty", 32'(exp_q.size()), 32'd0);

      // test 4: slave absent, bytes are dropped one per cycle
      m_din = 32'h5f;
      exp_w(8'h5f);
      exp_r;
      pulse_redetect;
      wait_idle("t4_det_idle");
      chk("t4_present", 32'(present), 32'd0);
      chk("t4_detdone", 32'(detect_done), 32'd1);
      in_valid = 1'b1;
      in_data = 8'h61;
      tick;
      in_data = 8'h62;
      tick;
      in_data = 8'h63;
      tick;
      in_valid = 1'b0;
      chk("t4_drop2", 32'(drop_cnt), 32'd2);
      chk("t4_busy_mid", 32'(busy), 32'd1);
      tick;
      chk("t4_drop3", 32'(drop_cnt), 32'd3);
      chk("t4_busy_end", 32'(busy), 32'd0);

      // test 5: redetect during P_CMD, pair completes, then lost slave
      m_din = 32'h21;
      exp_w(8'h5f);
      exp_r;
      pulse_redetect;
      wait_idle("t5_det_idle");
      chk("t5_present_on", 32'(present), 32'd1);
      exp_w(8'h70);
      exp_w(8'h31);
      exp_w(8'h5f);
      exp_r;
      in_valid = 1'b1;
      in_data = 8'h31;
      tick;
      in_data = 8'h32;
      tick;
      in_data = 8'h33;
      redetect = 1'b1;
      m_din = 32'h00;
      tick;
      in_valid = 1'b0;
      redetect = 1'b0;
      wait_idle("t5_idle");
      chk("t5_present_off", 32'(present), 32'd0);
      chk("t5_drop", 32'(drop_cnt), 32'd5);

      // test 6: reset pulse during P_CMD
      m_din = 32'h21;
      exp_w(8'h5f);
      exp_r;
      pulse_redetect;
      wait_idle("t6_det_idle");
      chk("t6_present_on", 32'(present), 32'd1);
      in_valid = 1'b1;
      in_data = 8'h55;
      tick;
      in_valid = 1'b0;
      tick;
      reset = 1'b0;
      exp_w(8'h00);
      exp_w(8'h5f);
      exp_r;
      @(negedge clk);
      chk("t6_cs_rst", 32'(m_cs), 32'd0);
      chk("t6_dout_rst", m_dout, 32'd0);
      tick;
      reset = 1'b1;
      chk("t6_present_rst", 32'(present), 32'd0);
      chk("t6_detdone_rst", 32'(detect_done), 32'd0);
      chk("t6_drop_rst", 32'(drop_cnt), 32'd0);
      chk("t6_busy_sync", 32'(busy), 32'd1);
      wait_idle("t6_idle");
      chk("t6_present", 32'(present), 32'd1);
      chk("t6_detdone", 32'(detect_done), 32'd1);
      repeat (3) tick;
      chk("final_q_empty", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
